dm_byte_mem: RTL and testbench

- Parametrised successor to the single-word data memory in the pipeline MEM stage.
- Adds byte/halfword/word stores with byte enables, and sign/zero-extended sub-word loads.
- Adds a registered one-cycle read, alignment and range error reporting, and a hardware clear sequencer that zeroes the array after reset instead of relying on a reset loop.
- Keeps the store trace line used by the course judge.

---
 rtl/dm_pkg.sv | 17 +
 rtl/dm_lane_align.sv | 49 ++++
 rtl/dm_byte_mem.sv | 125 ++++++++++++
 tb/tb_dm_byte_mem.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings for the byte-addressable data memory
package dm_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_BAD = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dm_state_e;

    // The store trace prints the word-aligned address, not the request address
    localparam logic [31:0] TRACE_ADDR_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - byte-lane steering for stores and sub-word load extraction
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    input  logic        sign,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rword[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        misalign  = 1'b0;
        ld_data   = rword;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                ld_data   = {{24{sign & ld_byte[7]}}, ld_byte};
            end
            SZ_H: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                misalign  = lane[0];
                ld_data   = {{16{sign & ld_half[15]}}, ld_half};
            end
            SZ_W: begin
                be       = 4'b1111;
                misalign = (lane != 2'b00);
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dm_byte_mem.sv
// rtl/dm_byte_mem.sv - data memory with sub-word access, error pulses and a post-reset clear sequencer
module dm_byte_mem
    import dm_pkg::*;
#(
    parameter int DEPTH    = 3072,
    parameter int IDX_W    = 12,
    parameter int TRACE_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        ready,
    output logic        rd_valid,
    output logic [31:0] rdata,
    output logic        err_misalign,
    output logic        err_range,
    output logic        init_busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dm_state_e       state, state_nxt;
    logic [AW-1:0]   clr_ptr;
    logic [31:0]     mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [AW-1:0]    widx;
    logic             in_range;
    logic             accept;
    logic [31:0]      rword;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic             misalign;
    logic [31:0]      ld_data;
    logic [31:0]      merged;
    logic             store_ok;
    logic             load_ok;
    logic             any_err;

    assign idx      = addr[IDX_W+1:2];
    assign widx     = idx[AW-1:0];
    assign in_range = (32'(idx) < 32'(DEPTH));
    assign accept   = req_valid && ready;
    // Out-of-range reads never touch the array, so the index is always legal
    assign rword    = in_range ? mem[widx] : 32'h0;

    dm_lane_align u_align (
        .size      (req_size),
        .lane      (addr[1:0]),
        .wdata     (wdata),
        .rword     (rword),
        .sign      (req_sign),
        .be        (be),
        .wdata_rep (wdata_rep),
        .misalign  (misalign),
        .ld_data   (ld_data)
    );

    always_comb begin
        merged = rword;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = wdata_rep[8*b +: 8];
        end
    end

    assign any_err  = misalign || !in_range;
    assign store_ok = accept && req_we && !any_err;
    assign load_ok  = accept && !req_we && !any_err;

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[clr_ptr] <= 32'h0;
        end else if (store_ok) begin
            mem[widx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_INIT;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT && clr_ptr != AW'(DEPTH - 1)) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && clr_ptr == AW'(DEPTH - 1)) state_nxt = ST_RUN;
    end

    always_comb begin
        ready     = (state == ST_RUN);
        init_busy = (state == ST_INIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid     <= 1'b0;
            rdata        <= 32'h0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            rd_valid     <= accept && !req_we;
            err_misalign <= accept && misalign;
            err_range    <= accept && !in_range;
            if (accept && any_err) rdata <= 32'h0;
            else if (load_ok)      rdata <= ld_data;
        end
    end

    if (TRACE_EN != 0) begin : g_trace
        always_ff @(posedge clk) begin
            if (store_ok) $display("%d@%h: *%h <= %h", $time, pc, addr & TRACE_ADDR_MASK, merged);
        end
    end

endmodule

// File: tb/tb_dm_byte_mem.sv
// tb/tb_dm_byte_mem.sv - directed table, corner sequences and randomized model checks for dm_byte_mem
module tb_dm_byte_mem;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        ready, rd_valid, err_misalign, err_range, init_busy;
    logic [31:0] rdata;

    dm_byte_mem #(.DEPTH(DEPTH), .IDX_W(12), .TRACE_EN(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .addr(addr), .wdata(wdata),
        .pc(pc), .ready(ready), .rd_valid(rd_valid), .rdata(rdata),
        .err_misalign(err_misalign), .err_range(err_range), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mb [DEPTH*4];
    logic [31:0] m_rdata;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rdv;
        logic [31:0] rd;
        logic        mis;
        logic        rng;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic we, input logic [1:0] size, input logic sign,
                                input logic [31:0] a, input logic [31:0] wd, input logic rdv,
                                input logic [31:0] rd, input logic mis, input logic rng);
        vec_t v;
        v.we = we; v.size = size; v.sign = sign; v.a = a; v.wd = wd;
        v.rdv = rdv; v.rd = rd; v.mis = mis; v.rng = rng;
        tbl.push_back(v);
    endfunction

    // Reference: byte-addressed little-endian memory, errors judged from natural alignment
    task automatic model_step(output logic e_rdv, output logic e_mis, output logic e_rng);
        int nb;
        logic [31:0] v;
        e_rdv = 1'b0; e_mis = 1'b0; e_rng = 1'b0;
        if (req_valid) begin
            nb = (req_size == 2'd3) ? 0 : (1 << req_size);
            e_mis = (nb == 0) || ((addr % nb) != 0);
            e_rng = (addr / 4) >= DEPTH;
            e_rdv = !req_we;
            if (e_mis || e_rng) begin
                m_rdata = 32'h0;
            end else if (req_we) begin
                for (int k = 0; k < nb; k++) mb[addr + k] = wdata[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < nb; k++) v = v | (32'(mb[addr + k]) << (8 * k));
                if (req_sign && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                m_rdata = v;
            end
        end
    endtask

    task automatic model_check(input string tag);
        logic e_rdv, e_mis, e_rng;
        model_step(e_rdv, e_mis, e_rng);
        tick();
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_rdv));
        chk({tag, ".rdata"}, rdata, m_rdata);
        chk({tag, ".err_misalign"}, 32'(err_misalign), 32'(e_mis));
        chk({tag, ".err_range"}, 32'(err_range), 32'(e_rng));
    endtask

    task automatic set_req(input logic v, input logic we, input logic [1:0] size,
                           input logic sign, input logic [31:0] a, input logic [31:0] wd);
        req_valid = v; req_we = we; req_size = size; req_sign = sign;
        addr = a; wdata = wd; pc = 32'h400 + a;
    endtask

    // Counts cycles with init_busy high, holding a store request that must be ignored
    task automatic count_init(input string tag);
        int n;
        n = 0;
        set_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF);
        while (init_busy && n < 20) begin
            chk({tag, ".ready_low"}, 32'(ready), 32'h0);
            n++;
            tick();
        end
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        chk({tag, ".init_cycles"}, 32'(n), 32'(DEPTH));
        chk({tag, ".ready_after"}, 32'(ready), 32'h1);
    endtask

    task automatic load_all_zero(input string tag);
        for (int w = 0; w < DEPTH; w++) begin
            set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * w), 32'h0);
            model_check({tag, ".zero"});
        end
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic e_rdv, e_mis, e_rng;
        int n;
        for (int i = 0; i < DEPTH * 4; i++) mb[i] = 8'h0;
        m_rdata = 32'h0;

        add(1, 2'b10, 0, 32'h10, 32'h1234_5678, 0, 32'h0000_0000, 0, 0);
        add(0, 2'b10, 0, 32'h10, 32'h0,         1, 32'h1234_5678, 0, 0);
        add(1, 2'b00, 0, 32'h11, 32'h0000_00AB, 0, 32'h1234_5678, 0, 0);
        add(0, 2'b10, 0, 32'h10, 32'h0,         1, 32'h1234_AB78, 0, 0);
        add(0, 2'b00, 1, 32'h11, 32'h0,         1, 32'hFFFF_FFAB, 0, 0);
        add(0, 2'b00, 0, 32'h11, 32'h0,         1, 32'h0000_00AB, 0, 0);
        add(0, 2'b01, 1, 32'h12, 32'h0,         1, 32'h0000_1234, 0, 0);
        add(0, 2'b10, 0, 32'h12, 32'h0,         1, 32'h0000_0000, 1, 0);
        add(1, 2'b01, 0, 32'h13, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1, 0);
        add(1, 2'b11, 0, 32'h00, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1, 0);
        add(0, 2'b10, 0, 32'h10, 32'h0,         1, 32'h1234_AB78, 0, 0);
        add(0, 2'b10, 0, 32'h20, 32'h0,         1, 32'h0000_0000, 0, 1);
        add(1, 2'b10, 0, 32'h20, 32'hCAFE_F00D, 0, 32'h0000_0000, 0, 1);
        add(0, 2'b10, 0, 32'h00, 32'h0,         1, 32'h0000_0000, 0, 0);
        add(0, 2'b10, 0, 32'h21, 32'h0,         1, 32'h0000_0000, 1, 1);
        add(1, 2'b01, 0, 32'h16, 32'h0000_8001, 0, 32'h0000_0000, 0, 0);
        add(0, 2'b01, 1, 32'h16, 32'h0,         1, 32'hFFFF_8001, 0, 0);
        add(0, 2'b01, 0, 32'h16, 32'h0,         1, 32'h0000_8001, 0, 0);
        add(0, 2'b00, 1, 32'h17, 32'h0,         1, 32'hFFFF_FF80, 0, 0);
        add(0, 2'b10, 0, 32'h14, 32'h0,         1, 32'h8001_0000, 0, 0);

        // Reset state
        tick();
        tick();
        chk("rst.ready", 32'(ready), 32'h0);
        chk("rst.init_busy", 32'(init_busy), 32'h1);
        chk("rst.rd_valid", 32'(rd_valid), 32'h0);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.errs", {30'h0, err_misalign, err_range}, 32'h0);

        reset = 1'b1;
        count_init("init1");
        load_all_zero("init1");

        // Directed table, back-to-back requests
        foreach (tbl[i]) begin
            set_req(1'b1, tbl[i].we, tbl[i].size, tbl[i].sign, tbl[i].a, tbl[i].wd);
            model_step(e_rdv, e_mis, e_rng);
            tick();
            chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].rdv));
            chk($sformatf("vec%0d.rdata", i), rdata, tbl[i].rd);
            chk($sformatf("vec%0d.err_misalign", i), 32'(err_misalign), 32'(tbl[i].mis));
            chk($sformatf("vec%0d.err_range", i), 32'(err_range), 32'(tbl[i].rng));
        end
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        model_check("idle");

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            set_req($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 4 * DEPTH + 7)), $urandom);
            model_check($sformatf("rnd%0d", i));
        end
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick();

        // Reset during the clear: the sweep restarts from zero
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk("midinit.busy", 32'(init_busy), 32'h1);
        reset = 1'b0;
        tick();
        chk("midinit.rst_busy", 32'(init_busy), 32'h1);
        chk("midinit.rst_ready", 32'(ready), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < DEPTH * 4; i++) mb[i] = 8'h0;
        m_rdata = 32'h0;
        count_init("init2");
        load_all_zero("init2");

        // Seed a word so a dropped load would be visible
        set_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h5555_AAAA);
        model_check("seed");

        // Reset right after a load is accepted drops its pulse
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        @(posedge clk);
        reset = 1'b0;
        #1;
        set_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        chk("ldrst.rd_valid", 32'(rd_valid), 32'h0);
        chk("ldrst.rdata", rdata, 32'h0);
        tick();
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (rd_valid) n++;
            tick();
        end
        chk("ldrst.no_pulse", 32'(n), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
